// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: per-register pending-write counters, RAW/full/CC hazard
// detection, and a branch-stall FSM with a watchdog that parks in ERROR on a lost resolve.
module hazard_scoreboard #(
    parameter int NUM_RF     = 16,
    parameter int IDX_W      = 4,
    parameter int CNT_W      = 2,
    parameter int BR_TIMEOUT = 64
) (
    input  logic              I_CLOCK,
    input  logic              I_RESET_N,
    input  logic              I_LOCK,
    input  logic              I_IssueValid,
    input  logic              I_Src1Used,
    input  logic              I_Src2Used,
    input  logic [IDX_W-1:0]  I_Src1Idx,
    input  logic [IDX_W-1:0]  I_Src2Idx,
    input  logic              I_DestUsed,
    input  logic [IDX_W-1:0]  I_DestIdx,
    input  logic              I_IsBranch,
    input  logic              I_NeedsCC,
    input  logic              I_WbValid,
    input  logic [IDX_W-1:0]  I_WbIdx,
    input  logic              I_BranchResolved,
    output logic              O_IssueReady,
    output logic              O_DepStall,
    output logic              O_BranchStall,
    output logic [NUM_RF-1:0] O_Busy,
    output logic              O_Error
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_ERROR   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [15:0]      WD_LAST  = 16'(BR_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [15:0]        wd_q, wd_d;
    logic [CNT_W-1:0]   cnt_q [NUM_RF];
    logic [CNT_W-1:0]   cnt_d [NUM_RF];
    logic [NUM_RF-1:0]  busy_q;
    logic               stall_q;
    logic               error_q;

    logic [NUM_RF-1:0]  wb_hit_s;
    logic [NUM_RF-1:0]  eff_busy_s;
    logic               hazard_s;
    logic               req_s;
    logic               issue_s;
    logic               underflow_s;

    // Same-cycle writeback bypass: a register whose only pending write retires now reads as free.
    always_comb begin
        wb_hit_s   = {NUM_RF{1'b0}};
        eff_busy_s = {NUM_RF{1'b0}};
        for (int r = 0; r < NUM_RF; r++) begin
            wb_hit_s[r]   = I_WbValid && (I_WbIdx == IDX_W'(r));
            eff_busy_s[r] = (cnt_q[r] != CNT_ZERO) && !(wb_hit_s[r] && (cnt_q[r] == CNT_ONE));
        end
    end

    // Hazard detection and issue decision.
    always_comb begin
        hazard_s = (I_Src1Used && eff_busy_s[I_Src1Idx])
                || (I_Src2Used && eff_busy_s[I_Src2Idx])
                || (I_DestUsed && (cnt_q[I_DestIdx] == CNT_MAX) && !wb_hit_s[I_DestIdx])
                || (I_NeedsCC && (|eff_busy_s));
        req_s    = I_RESET_N && I_LOCK && I_IssueValid && (state_q == ST_IDLE);
        issue_s  = req_s && !hazard_s;
    end

    assign O_IssueReady = issue_s;
    assign O_DepStall   = req_s && hazard_s;

    // Counter next state; a simultaneous issue and writeback on one register cancel out.
    always_comb begin
        underflow_s = I_WbValid && (cnt_q[I_WbIdx] == CNT_ZERO);
        for (int r = 0; r < NUM_RF; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue_s && I_DestUsed && (I_DestIdx == IDX_W'(r))) begin
                if (!wb_hit_s[r]) begin
                    cnt_d[r] = cnt_q[r] + CNT_ONE;
                end else begin
                    cnt_d[r] = cnt_q[r];
                end
            end else if (wb_hit_s[r] && (cnt_q[r] != CNT_ZERO)) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
    end

    // Branch FSM next state and watchdog; resolve takes priority over expiry.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_s && I_IsBranch) begin
                    state_d = ST_BR_WAIT;
                    wd_d    = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BR_WAIT: begin
                if (I_BranchResolved) begin
                    state_d = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge I_CLOCK) begin
        if (!I_RESET_N) begin
            state_q <= ST_IDLE;
            wd_q    <= 16'd0;
            for (int r = 0; r < NUM_RF; r++) begin
                cnt_q[r] <= CNT_ZERO;
            end
            busy_q  <= {NUM_RF{1'b0}};
            stall_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            for (int r = 0; r < NUM_RF; r++) begin
                cnt_q[r]  <= cnt_d[r];
                busy_q[r] <= (cnt_d[r] != CNT_ZERO);
            end
            stall_q <= (state_d == ST_BR_WAIT);
            error_q <= error_q || underflow_s || (state_d == ST_ERROR);
        end
    end

    assign O_BranchStall = stall_q;
    assign O_Busy        = busy_q;
    assign O_Error       = error_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed test-plan scenarios followed by
// randomized traffic, all compared against a counter/queue-level reference model.
module tb_hazard_scoreboard;

    logic        I_CLOCK = 1'b0;
    logic        I_RESET_N, I_LOCK, I_IssueValid, I_Src1Used, I_Src2Used;
    logic [3:0]  I_Src1Idx, I_Src2Idx, I_DestIdx, I_WbIdx;
    logic        I_DestUsed, I_IsBranch, I_NeedsCC, I_WbValid, I_BranchResolved;
    logic        O_IssueReady, O_DepStall, O_BranchStall, O_Error;
    logic [15:0] O_Busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain integer counters, mode 0=idle 1=branch wait 2=error.
    int cnt_m [16];
    int mode_m;
    int wd_m;
    bit err_m;

    always #5 I_CLOCK = ~I_CLOCK;

    hazard_scoreboard #(.NUM_RF(16), .IDX_W(4), .CNT_W(2), .BR_TIMEOUT(64)) dut (
        .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK),
        .I_IssueValid(I_IssueValid), .I_Src1Used(I_Src1Used), .I_Src2Used(I_Src2Used),
        .I_Src1Idx(I_Src1Idx), .I_Src2Idx(I_Src2Idx), .I_DestUsed(I_DestUsed),
        .I_DestIdx(I_DestIdx), .I_IsBranch(I_IsBranch), .I_NeedsCC(I_NeedsCC),
        .I_WbValid(I_WbValid), .I_WbIdx(I_WbIdx), .I_BranchResolved(I_BranchResolved),
        .O_IssueReady(O_IssueReady), .O_DepStall(O_DepStall), .O_BranchStall(O_BranchStall),
        .O_Busy(O_Busy), .O_Error(O_Error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int r);
        int e;
        e = cnt_m[r] - ((I_WbValid && int'(I_WbIdx) == r) ? 1 : 0);
        return (e < 0) ? 0 : e;
    endfunction

    function automatic bit model_hazard();
        bit h = 1'b0;
        if (I_Src1Used && eff(int'(I_Src1Idx)) != 0) h = 1'b1;
        if (I_Src2Used && eff(int'(I_Src2Idx)) != 0) h = 1'b1;
        if (I_DestUsed && cnt_m[I_DestIdx] == 3 && !(I_WbValid && I_WbIdx == I_DestIdx)) h = 1'b1;
        if (I_NeedsCC) begin
            for (int r = 0; r < 16; r++) if (eff(r) != 0) h = 1'b1;
        end
        return h;
    endfunction

    function automatic bit model_req();
        return I_RESET_N && I_LOCK && I_IssueValid && (mode_m == 0);
    endfunction

    function automatic logic [15:0] model_busy();
        logic [15:0] b = 16'h0000;
        for (int r = 0; r < 16; r++) b[r] = (cnt_m[r] != 0);
        return b;
    endfunction

    task automatic model_update(input bit iss);
        if (!I_RESET_N) begin
            foreach (cnt_m[r]) cnt_m[r] = 0;
            mode_m = 0;
            wd_m   = 0;
            err_m  = 1'b0;
        end else begin
            if (I_WbValid && cnt_m[I_WbIdx] == 0) err_m = 1'b1;
            if (iss && I_DestUsed) cnt_m[I_DestIdx] = cnt_m[I_DestIdx] + 1;
            if (I_WbValid) cnt_m[I_WbIdx] = (cnt_m[I_WbIdx] > 0) ? cnt_m[I_WbIdx] - 1 : 0;
            if (mode_m == 0) begin
                if (iss && I_IsBranch) begin
                    mode_m = 1;
                    wd_m   = 0;
                end
            end else if (mode_m == 1) begin
                if (I_BranchResolved) mode_m = 0;
                else if (wd_m == 63) mode_m = 2;
                else wd_m = wd_m + 1;
            end
            if (mode_m == 2) err_m = 1'b1;
        end
    endtask

    task automatic clear_inputs();
        I_RESET_N = 1'b1; I_LOCK = 1'b1; I_IssueValid = 1'b0;
        I_Src1Used = 1'b0; I_Src2Used = 1'b0; I_Src1Idx = 4'd0; I_Src2Idx = 4'd0;
        I_DestUsed = 1'b0; I_DestIdx = 4'd0; I_IsBranch = 1'b0; I_NeedsCC = 1'b0;
        I_WbValid = 1'b0; I_WbIdx = 4'd0; I_BranchResolved = 1'b0;
    endtask

    // One clock: inputs are already driven (just after a negedge).
    task automatic step();
        bit req, haz;
        #1;
        req = model_req();
        haz = model_hazard();
        check_eq("issue_ready", O_IssueReady, req && !haz);
        check_eq("dep_stall", O_DepStall, req && haz);
        @(posedge I_CLOCK);
        model_update(req && !haz);
        @(negedge I_CLOCK);
        check_eq("busy", O_Busy, model_busy());
        check_eq("branch_stall", O_BranchStall, mode_m == 1);
        check_eq("error", O_Error, err_m);
    endtask

    task automatic do_reset(input int cycles);
        clear_inputs();
        I_RESET_N = 1'b0;
        repeat (cycles) step();
        I_RESET_N = 1'b1;
    endtask

    task automatic alu(input logic [3:0] dst, input bit s1u, input logic [3:0] s1);
        clear_inputs();
        I_IssueValid = 1'b1; I_DestUsed = 1'b1; I_DestIdx = dst;
        I_Src1Used = s1u; I_Src1Idx = s1;
    endtask

    initial begin
        foreach (cnt_m[r]) cnt_m[r] = 0;
        mode_m = 0; wd_m = 0; err_m = 1'b0;
        clear_inputs();
        @(negedge I_CLOCK);
        do_reset(2);
        check_eq("reset_busy", O_Busy, 16'h0000);
        check_eq("reset_error", O_Error, 1'b0);

        // RAW on R1 held until its writeback arrives, then bypassed.
        alu(4'd1, 1'b0, 4'd0); step();
        alu(4'd3, 1'b1, 4'd1); #1;
        check_eq("raw_hold_dep", O_DepStall, 1'b1);
        check_eq("raw_hold_issue", O_IssueReady, 1'b0);
        step(); step();
        I_WbValid = 1'b1; I_WbIdx = 4'd1; #1;
        check_eq("raw_bypass_issue", O_IssueReady, 1'b1);
        step();
        check_eq("raw_busy1_clear", O_Busy[1], 1'b0);
        clear_inputs(); I_WbValid = 1'b1; I_WbIdx = 4'd3; step();

        // Counter saturation on R2.
        repeat (3) begin alu(4'd2, 1'b0, 4'd0); step(); end
        alu(4'd2, 1'b0, 4'd0); #1;
        check_eq("full_hold", O_DepStall, 1'b1);
        step();
        I_WbValid = 1'b1; I_WbIdx = 4'd2; #1;
        check_eq("full_wb_issue", O_IssueReady, 1'b1);
        step();
        check_eq("full_busy2", O_Busy[2], 1'b1);
        repeat (3) begin clear_inputs(); I_WbValid = 1'b1; I_WbIdx = 4'd2; step(); end
        check_eq("full_drained", O_Busy, 16'h0000);

        // CC-dependent branch held on pending R5, then the branch stall sequence.
        alu(4'd5, 1'b0, 4'd0); step();
        clear_inputs(); I_IssueValid = 1'b1; I_IsBranch = 1'b1; I_NeedsCC = 1'b1; #1;
        check_eq("cc_hold", O_DepStall, 1'b1);
        step();
        I_WbValid = 1'b1; I_WbIdx = 4'd5; #1;
        check_eq("cc_issue", O_IssueReady, 1'b1);
        step();
        check_eq("br_stall_up", O_BranchStall, 1'b1);
        alu(4'd4, 1'b0, 4'd0); step();
        check_eq("br_wait_blocked", O_IssueReady, 1'b0);
        I_BranchResolved = 1'b1; step();
        I_BranchResolved = 1'b0; #1;
        check_eq("br_after_resolve", O_IssueReady, 1'b1);
        step();
        clear_inputs(); I_WbValid = 1'b1; I_WbIdx = 4'd4; step();

        // Watchdog expiry with a JSR (R7 destination), then reset recovery.
        clear_inputs(); I_IssueValid = 1'b1; I_IsBranch = 1'b1; I_DestUsed = 1'b1; I_DestIdx = 4'd7;
        step();
        clear_inputs();
        repeat (63) step();
        check_eq("wd_not_yet", O_Error, 1'b0);
        step();
        check_eq("wd_error", O_Error, 1'b1);
        check_eq("wd_stall_drop", O_BranchStall, 1'b0);
        alu(4'd1, 1'b0, 4'd0); step();
        do_reset(1);
        check_eq("post_reset_err", O_Error, 1'b0);
        check_eq("post_reset_busy", O_Busy, 16'h0000);
        alu(4'd1, 1'b0, 4'd0); #1;
        check_eq("post_reset_issue", O_IssueReady, 1'b1);
        step();
        clear_inputs(); I_WbValid = 1'b1; I_WbIdx = 4'd1; step();

        // Underflow on idle R9, then writeback under I_LOCK=0.
        clear_inputs(); I_WbValid = 1'b1; I_WbIdx = 4'd9; step();
        check_eq("underflow_err", O_Error, 1'b1);
        check_eq("underflow_busy9", O_Busy[9], 1'b0);
        alu(4'd6, 1'b0, 4'd0); step();
        alu(4'd8, 1'b0, 4'd0); I_LOCK = 1'b0; I_WbValid = 1'b1; I_WbIdx = 4'd6; #1;
        check_eq("lock_no_issue", O_IssueReady, 1'b0);
        step();
        check_eq("lock_wb_applied", O_Busy, 16'h0000);

        // Randomized traffic; writebacks target only pending registers.
        do_reset(1);
        for (int c = 0; c < 3000; c++) begin
            int pend [$];
            clear_inputs();
            I_RESET_N    = ($urandom_range(0, 299) != 0);
            I_LOCK       = ($urandom_range(0, 7) != 0);
            I_IssueValid = ($urandom_range(0, 3) != 0);
            I_Src1Used   = $urandom_range(0, 1);
            I_Src2Used   = $urandom_range(0, 1);
            I_Src1Idx    = 4'($urandom_range(0, 7));
            I_Src2Idx    = 4'($urandom_range(0, 7));
            I_DestUsed   = $urandom_range(0, 1);
            I_DestIdx    = 4'($urandom_range(0, 7));
            I_IsBranch   = ($urandom_range(0, 11) == 0);
            I_NeedsCC    = I_IsBranch && ($urandom_range(0, 1) == 1);
            I_BranchResolved = ($urandom_range(0, 5) == 0);
            for (int r = 0; r < 16; r++) if (cnt_m[r] != 0) pend.push_back(r);
            if (pend.size() != 0 && $urandom_range(0, 2) != 0) begin
                I_WbValid = 1'b1;
                I_WbIdx   = 4'(pend[$urandom_range(0, pend.size() - 1)]);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Issue controller for the 5-stage pipeline's decode stage. Tracks in-flight writes to each scalar register with per-register pending counters.
- Decides each cycle whether the instruction in decode may issue, holding it on RAW hazards, counter saturation and unresolved control flow.
- Sequences the branch stall to fetch with a small FSM and a watchdog; replaces the valid-bit and stall logic inside decode.

Parameters:
- NUM_RF, 16, number of scalar registers tracked.
- IDX_W, 4, register index width; 2^IDX_W >= NUM_RF.
- CNT_W, 2, pending-counter width; max in-flight writes per register = 2^CNT_W-1.
- BR_TIMEOUT, 64, cycles allowed in BR_WAIT before the error state; 16-bit watchdog counter.

Ports:
- I_CLOCK  in  1  clock; all state updates on posedge.
- I_RESET_N  in  1  synchronous active-low reset.
- I_LOCK  in  1  pipeline enable; when low, no issue is accepted.
- I_IssueValid  in  1  decode holds a real (non-fetch-stall) instruction.
- I_Src1Used / I_Src2Used  in  1 each  source operand is read.
- I_Src1Idx / I_Src2Idx  in  IDX_W each  source register index.
- I_DestUsed  in  1  instruction writes a register.
- I_DestIdx  in  IDX_W  destination index; JSR/JSRR present 7.
- I_IsBranch  in  1  BR*/JMP/JSR/JSRR.
- I_NeedsCC  in  1  conditional branch: condition code must be final.
- I_WbValid  in  1  writeback this cycle.
- I_WbIdx  in  IDX_W  writeback register index.
- I_BranchResolved  in  1  execute has produced the branch target.
- O_IssueReady  out  1  combinational: the decode instruction issues this cycle.
- O_DepStall  out  1  combinational: valid instruction held by a data hazard.
- O_BranchStall  out  1  registered: fetch must hold (state == BR_WAIT).
- O_Busy  out  NUM_RF  registered: bit r = (cnt[r] != 0).
- O_Error  out  1  registered, sticky: watchdog expiry or writeback underflow.

Behaviour:
- Reset (I_RESET_N=0 at posedge): all cnt=0, state=IDLE, watchdog=0. O_BranchStall, O_Busy and O_Error are 0. While I_RESET_N is low, O_IssueReady=0 and O_DepStall=0. Reset mid-branch returns to IDLE and drops any in-flight bookkeeping.
- Effective count for a register, same cycle: eff[r] = cnt[r] - (I_WbValid && I_WbIdx==r). This gives same-cycle writeback bypass.
- A source hazard exists when Used && eff[idx] != 0.
- Full hazard: I_DestUsed && cnt[I_DestIdx] == max && !(writeback to I_DestIdx this cycle).
- CC hazard: I_NeedsCC && any eff[r] != 0.
- O_IssueReady = I_RESET_N && I_LOCK && I_IssueValid && state==IDLE && no hazard of any kind.
- O_DepStall = I_RESET_N && I_LOCK && I_IssueValid && state==IDLE && any hazard.
- Counter update at posedge: +1 on cnt[I_DestIdx] if the instruction issues with I_DestUsed. −1 on cnt[I_WbIdx] if I_WbValid.
- Increment and decrement on the same register in the same cycle leave the count unchanged.
- Decrement of a zero counter: counter stays 0 and O_Error is set.
- Writebacks are applied regardless of I_LOCK or FSM state.
- FSM states: IDLE, BR_WAIT, ERROR.
  - IDLE → BR_WAIT when an issue occurs with I_IsBranch=1; the watchdog clears.
  - BR_WAIT: issue is blocked and the watchdog increments each cycle. On I_BranchResolved → IDLE; the next instruction may issue on the first IDLE cycle. I_BranchResolved is ignored outside BR_WAIT.
  - BR_WAIT with watchdog == BR_TIMEOUT-1 and no resolve → ERROR. If resolve arrives in the same cycle as expiry, resolve wins.
  - ERROR: issue is blocked, O_BranchStall=0, O_Error=1. Leaves only on reset.
- Issue-to-stall latency: a branch issued at edge N raises O_BranchStall after edge N. Branch destination (JSR R7) is counted like any other destination.
- O_Busy reflects counters after the posedge update.

Test Plan:
- ADD R1 issues at cycle 0, then ADD using R1 presented at cycle 1 with no writeback → O_DepStall=1 and O_IssueReady=0. I_WbValid, I_WbIdx=1 at cycle 3 → issue at cycle 3 (bypass); O_Busy[1] returns to 0.
- Four back-to-back writes to R2 with no writeback → first three issue; the fourth is held (cnt=3, CNT_W=2). A writeback to R2 in the fourth cycle → it issues and cnt stays 3.
- BRZ with I_NeedsCC while R5 is pending → held. After writeback to R5 → issues; O_BranchStall=1 next cycle. Subsequent instruction is held until I_BranchResolved, then issues the cycle after.
- Branch issued and I_BranchResolved never asserted → O_Error=1 and state ERROR after 64 cycles. I_RESET_N low for 1 cycle → all outputs 0 and issue resumes.
- Writeback to idle R9 → cnt[9] stays 0, O_Error=1. I_LOCK=0 with a pending writeback → no issue, but the counter still decrements.
